// File: rtl/pipe_wb_stage.sv
// pipe_wb_stage: MEM/WB pipeline register with load extraction, result select and retired-instruction counter
//   clk, clrn         : rising-edge clock, asynchronous active-low reset
//   stall, flush      : hold / bubble the MEM/WB register (flush wins)
//   mvalid, malu, mmo : MEM-stage valid, ALU/link result (low bits = load byte address), raw memory word
//   mwreg, mm2reg     : writes a register, result comes from memory
//   mldt, mrn         : load type, destination register
//   wdi, wrn, wwreg   : register-file write port / forwarding path in WB
//   wvalid, instret   : WB slot valid, retired-instruction count
module pipe_wb_stage #(
  parameter int DW       = 32,
  parameter int RW       = 5,
  parameter int CW       = 32,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          stall,
  input  logic          flush,
  input  logic          mvalid,
  input  logic [DW-1:0] malu,
  input  logic [DW-1:0] mmo,
  input  logic          mwreg,
  input  logic          mm2reg,
  input  logic [2:0]    mldt,
  input  logic [RW-1:0] mrn,
  output logic [DW-1:0] wdi,
  output logic [RW-1:0] wrn,
  output logic          wwreg,
  output logic          wvalid,
  output logic [CW-1:0] instret
);
  localparam int OW = $clog2(DW / 8);
  logic          valid_q, valid_d, wreg_q, wreg_d, m2reg_q, m2reg_d;
  logic [2:0]    ldt_q, ldt_d;
  logic [RW-1:0] rn_q, rn_d;
  logic [DW-1:0] alu_q, alu_d, mo_q, mo_d, ld;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] off, off_h, off_w;
  logic [7:0]    b8;
  logic [15:0]   h16;
  logic [31:0]   w32;
  always_comb begin
    valid_d = flush ? 1'b0 : stall ? valid_q : mvalid;
    wreg_d  = flush ? 1'b0 : stall ? wreg_q  : mwreg;
    m2reg_d = flush ? 1'b0 : stall ? m2reg_q : mm2reg;
    ldt_d   = flush ? 3'b0 : stall ? ldt_q   : mldt;
    rn_d    = flush ? '0   : stall ? rn_q    : mrn;
    alu_d   = flush ? '0   : stall ? alu_q   : malu;
    mo_d    = flush ? '0   : stall ? mo_q    : mmo;
    cnt_d   = cnt_q + CW'(mvalid & ~stall & ~flush);
  end
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      valid_q <= 1'b0;
      wreg_q  <= 1'b0;
      m2reg_q <= 1'b0;
      ldt_q   <= 3'b0;
      rn_q    <= '0;
      alu_q   <= '0;
      mo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      wreg_q  <= wreg_d;
      m2reg_q <= m2reg_d;
      ldt_q   <= ldt_d;
      rn_q    <= rn_d;
      alu_q   <= alu_d;
      mo_q    <= mo_d;
      cnt_q   <= cnt_d;
    end
  end
  // Lane offsets are aligned down to the access size; for DW=32 the word offset is always 0,
  // so LD and LWU collapse onto LW without special casing.
  always_comb begin
    off   = alu_q[OW-1:0];
    off_h = off & ~OW'(1);
    off_w = off & ~OW'(3);
    b8    = 8'(mo_q >> {off, 3'b000});
    h16   = 16'(mo_q >> {off_h, 3'b000});
    w32   = 32'(mo_q >> {off_w, 3'b000});
    case (ldt_q)
      3'b000:  ld = DW'($signed(b8));
      3'b001:  ld = DW'($signed(h16));
      3'b010:  ld = DW'($signed(w32));
      3'b100:  ld = DW'(b8);
      3'b101:  ld = DW'(h16);
      3'b110:  ld = DW'(w32);
      default: ld = mo_q;
    endcase
  end
  assign wdi     = m2reg_q ? ld : alu_q;
  assign wrn     = rn_q;
  assign wvalid  = valid_q;
  assign wwreg   = wreg_q & valid_q & ~((ZERO_REG != 0) && (rn_q == '0));
  assign instret = cnt_q;
endmodule
